// File: rtl/axi_wr_slave.sv
// AXI write-channel slave: AW/W/B handshakes into a byte-strobed word memory
// with a combinational debug read port. Optional WID compare: AXI_WR_SLAVE_WID_CHECK_EN.
module axi_wr_slave #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SIZE  = 3,
   parameter int unsigned DEPTH = 256
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     AWVALID,
   output logic                     AWREADY,
   input  logic [WIDTH/8-1:0]       AWID,
   input  logic [WIDTH-1:0]         AWADDR,
   input  logic [WIDTH/8-1:0]       AWLEN,
   input  logic [SIZE-1:0]          AWSIZE,
   input  logic [SIZE-2:0]          AWBURST,
   input  logic                     WVALID,
   output logic                     WREADY,
   input  logic [WIDTH/8-1:0]       WID,
   input  logic [WIDTH-1:0]         WDATA,
   input  logic [WIDTH/8-1:0]       WSTRB,
   input  logic                     WLAST,
   output logic                     BVALID,
   input  logic                     BREADY,
   output logic [WIDTH/8-1:0]       BID,
   output logic [SIZE-2:0]          BRESP,
   input  logic [$clog2(DEPTH)-1:0] dbg_addr,
   output logic [WIDTH-1:0]         dbg_rdata
);

   localparam int unsigned LANES = WIDTH / 8;
   localparam int unsigned LSB   = $clog2(LANES);
   localparam int unsigned AW    = $clog2(DEPTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [SIZE-2:0] BURST_FIXED = (SIZE-1)'(0);
   localparam logic [SIZE-2:0] BURST_INCR  = (SIZE-1)'(1);
   localparam logic [SIZE-2:0] BURST_WRAP  = (SIZE-1)'(2);
   localparam logic [SIZE-2:0] BURST_RSVD  = (SIZE-1)'(3);
   localparam logic [SIZE-2:0] RESP_OKAY   = (SIZE-1)'(0);
   localparam logic [SIZE-2:0] RESP_SLVERR = (SIZE-1)'(2);

   logic [1:0]       state;
   logic             awready;
   logic [LANES-1:0] lat_id, lat_len, cnt, bid;
   logic [WIDTH-1:0] cur_addr, step, bound, next_addr, word_idx;
   logic [SIZE-1:0]  lat_size;
   logic [SIZE-2:0]  lat_burst, bresp;
   logic             err, wrap_len_ok, size_err, cfg_err, range_err, wid_err;
   logic             beat, beat_wr, len_hit, beat_last, beat_err;
   logic [WIDTH-1:0] mem [DEPTH];

`ifdef AXI_WR_SLAVE_WID_CHECK_EN
   assign wid_err = (WID != lat_id);
`else
   logic unused_wid;
   assign unused_wid = ^WID;
   assign wid_err    = 1'b0;
`endif

   always_comb begin
      step        = WIDTH'(1) << lat_size;
      bound       = (WIDTH'(lat_len) + WIDTH'(1)) << lat_size;
      word_idx    = cur_addr >> LSB;
      wrap_len_ok = (lat_len == LANES'(1)) || (lat_len == LANES'(3)) ||
                    (lat_len == LANES'(7)) || (lat_len == LANES'(15));
      size_err    = step > WIDTH'(LANES);
      cfg_err     = (lat_burst == BURST_RSVD) ||
                    ((lat_burst == BURST_WRAP) && !wrap_len_ok) || size_err;
      range_err   = word_idx >= WIDTH'(DEPTH);
      beat        = (state == S_DATA) && WVALID;
      beat_wr     = beat && !cfg_err && !range_err && !wid_err;
      len_hit     = (cnt == lat_len);
      beat_last   = len_hit || WLAST;
      // WLAST disagreeing with the beat count is flagged but still ends the burst
      beat_err    = cfg_err || range_err || wid_err || (WLAST != len_hit);
      next_addr   = cur_addr;
      case (lat_burst)
         BURST_FIXED: next_addr = cur_addr;
         BURST_INCR:  next_addr = cur_addr + step;
         BURST_WRAP:  next_addr = (cur_addr & ~(bound - WIDTH'(1))) |
                                  ((cur_addr + step) & (bound - WIDTH'(1)));
         default:     next_addr = cur_addr;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         awready   <= 1'b0;
         lat_id    <= '0;
         lat_len   <= '0;
         lat_size  <= '0;
         lat_burst <= '0;
         cur_addr  <= '0;
         cnt       <= '0;
         err       <= 1'b0;
         bid       <= '0;
         bresp     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (AWVALID && awready) begin
                  lat_id    <= AWID;
                  cur_addr  <= AWADDR;
                  lat_len   <= AWLEN;
                  lat_size  <= AWSIZE;
                  lat_burst <= AWBURST;
                  cnt       <= '0;
                  err       <= 1'b0;
                  awready   <= 1'b0;
                  state     <= S_DATA;
               end else begin
                  awready <= 1'b1;
               end
            end
            S_DATA: begin
               if (beat) begin
                  cnt      <= cnt + LANES'(1);
                  cur_addr <= next_addr;
                  if (beat_err) err <= 1'b1;
                  if (beat_last) begin
                     state <= S_RESP;
                     bid   <= lat_id;
                     bresp <= (err || beat_err) ? RESP_SLVERR : RESP_OKAY;
                  end
               end
            end
            S_RESP: begin
               if (BREADY) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Memory is deliberately left out of reset so aborted bursts keep their beats
   always_ff @(posedge clk) begin
      if (beat_wr) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (WSTRB[i]) mem[word_idx[AW-1:0]][i*8 +: 8] <= WDATA[i*8 +: 8];
         end
      end
   end

   assign AWREADY   = awready;
   assign WREADY    = (state == S_DATA);
   assign BVALID    = (state == S_RESP);
   assign BID       = bid;
   assign BRESP     = bresp;
   assign dbg_rdata = mem[dbg_addr];

endmodule

// File: tb/tb_axi_wr_slave.sv
// Randomized scoreboard bench for axi_wr_slave: a behavioural memory model predicts
// contents and B responses; a monitor process checks responses as the DUT offers them.
`timescale 1ns/1ps
module tb_axi_wr_slave;
   localparam int unsigned DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
   logic [3:0]  AWID, AWLEN, WID, WSTRB, BID;
   logic [31:0] AWADDR, WDATA, dbg_rdata;
   logic [2:0]  AWSIZE;
   logic [1:0]  AWBURST, BRESP;
   logic [7:0]  dbg_addr;

   always #5 clk = ~clk;

   axi_wr_slave #(.WIDTH(32), .SIZE(3), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(rst_n),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWADDR(AWADDR),
      .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .WVALID(WVALID), .WREADY(WREADY), .WID(WID), .WDATA(WDATA),
      .WSTRB(WSTRB), .WLAST(WLAST),
      .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
      .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
   );

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic [31:0] model_mem [DEPTH];
   logic [5:0]  sb [$];
   logic [31:0] bd [16];
   logic [3:0]  bs [16];
   logic        bl [16];
   logic [3:0]  bw [16];
   int unsigned bp_mode = 0;
   logic        bready_man = 1'b1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Reference: walk the beats by the address rules, apply writes, return expected BRESP.
   function automatic logic [1:0] model_burst(input logic [3:0] id, input logic [31:0] addr,
         input int unsigned len, input int unsigned size, input int unsigned burst,
         input int unsigned max_beats, output int unsigned nb);
      int unsigned step, bound, word;
      logic [31:0] cur;
      bit err, cfg_bad, drop, last, wid_chk;
`ifdef AXI_WR_SLAVE_WID_CHECK_EN
      wid_chk = 1'b1;
`else
      wid_chk = 1'b0;
`endif
      step    = 1 << size;
      bound   = (len + 1) * step;
      cur     = addr;
      err     = 1'b0;
      nb      = 0;
      cfg_bad = (burst == 3) || (burst == 2 && !(len inside {1, 3, 7, 15})) || (step > 4);
      for (int unsigned k = 0; k < 16 && k < max_beats; k++) begin
         word = cur / 4;
         drop = cfg_bad || (word >= DEPTH) || (wid_chk && bw[k] != id);
         last = (k == len) || bl[k];
         if (drop) err = 1'b1;
         if (bl[k] != (k == len)) err = 1'b1;
         if (!drop)
            for (int unsigned b = 0; b < 4; b++)
               if (bs[k][b]) model_mem[word][8*b +: 8] = bd[k][8*b +: 8];
         if (burst == 1) cur = cur + step;
         else if (burst == 2) cur = (cur / bound) * bound + ((cur + step) % bound);
         nb++;
         if (last) break;
      end
      return err ? 2'd2 : 2'd0;
   endfunction

   task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
      int unsigned n = 0;
      @(negedge clk);
      AWVALID = 1'b1; AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
      while (!AWREADY && n < 50) begin @(negedge clk); n++; end
      if (!AWREADY) begin
         total++; bad++;
         $display("FAIL awready_timeout: got AWREADY=0 required 1");
      end
      @(negedge clk);
      AWVALID = 1'b0;
   endtask

   task automatic drive_beats(input int unsigned nb, input bit bubbles);
      for (int unsigned k = 0; k < nb; k++) begin
         int unsigned n;
         if (bubbles && $urandom_range(0, 3) == 0) begin WVALID = 1'b0; @(negedge clk); end
         WVALID = 1'b1; WDATA = bd[k]; WSTRB = bs[k]; WLAST = bl[k]; WID = bw[k];
         n = 0;
         while (!WREADY && n < 50) begin @(negedge clk); n++; end
         if (!WREADY) begin
            total++; bad++;
            $display("FAIL wready_timeout: got WREADY=0 at beat %0d required 1", k);
            WVALID = 1'b0;
            return;
         end
         @(negedge clk);
      end
      WVALID = 1'b0; WLAST = 1'b0;
   endtask

   task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit bubbles);
      int unsigned nb;
      logic [1:0] resp;
      resp = model_burst(id, addr, len, size, burst, 16, nb);
      sb.push_back({id, resp});
      do_aw(id, addr, len, size, burst);
      drive_beats(nb, bubbles);
   endtask

   task automatic wait_resp();
      int unsigned n = 0;
      while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
      if (sb.size() != 0) begin
         total++; bad++;
         $display("FAIL resp_timeout: got %0d pending responses required 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic read_word(input int unsigned w, output logic [31:0] d);
      dbg_addr = 8'(w);
      #0.01;
      d = dbg_rdata;
   endtask

   task automatic sweep(input string tag);
      logic [31:0] d;
      @(negedge clk);
      for (int unsigned w = 0; w < DEPTH; w++) begin
         read_word(w, d);
         check($sformatf("%s_mem[%0d]", tag, w), d, model_mem[w]);
      end
   endtask

   task automatic fill(input logic [3:0] id, input int unsigned len);
      for (int unsigned k = 0; k < 16; k++) begin
         bd[k] = $urandom; bs[k] = 4'hF; bl[k] = (k == len); bw[k] = id;
      end
   endtask

   initial begin : bready_drv
      BREADY = 1'b0;
      forever begin
         @(negedge clk);
         if (bp_mode == 0) BREADY = 1'b1;
         else if (bp_mode == 1) BREADY = ($urandom_range(0, 1) == 1);
         else BREADY = bready_man;
      end
   end

   initial begin : monitor
      logic [3:0] pid;
      logic [1:0] presp;
      logic [5:0] e;
      bit pstall, phs;
      pstall = 1'b0; phs = 1'b0; pid = '0; presp = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin pstall = 1'b0; phs = 1'b0; continue; end
         if (phs) check("bvalid_one_cycle", BVALID, 0);
         if (pstall) begin
            check("bvalid_hold", BVALID, 1);
            check("bid_hold", BID, pid);
            check("bresp_hold", BRESP, presp);
         end
         if (BVALID) check("awready_in_resp", AWREADY, 0);
         phs = 1'b0; pstall = 1'b0;
         if (BVALID && BREADY) begin
            if (sb.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_resp: got bid=%h bresp=%h required no response", BID, BRESP);
            end else begin
               e = sb.pop_front();
               check("bid", BID, e[5:2]);
               check("bresp", BRESP, e[1:0]);
            end
            phs = 1'b1;
         end else if (BVALID) begin
            pstall = 1'b1; pid = BID; presp = BRESP;
         end
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: got no completion required finish before 900us");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [31:0] d;
      int unsigned nb, n;
      logic [1:0] r;
      AWVALID = 0; AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0;
      WVALID = 0; WID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; dbg_addr = 0;
      #12;
      check("rst_awready", AWREADY, 0);
      check("rst_wready", WREADY, 0);
      check("rst_bvalid", BVALID, 0);
      check("rst_bid", BID, 0);
      check("rst_bresp", BRESP, 0);
      @(negedge clk); rst_n = 1'b1;
      #1 check("awready_before_clk", AWREADY, 0);
      @(negedge clk);
      check("awready_after_rst", AWREADY, 1);
      check("wready_idle", WREADY, 0);

      for (int unsigned b = 0; b < 16; b++) begin
         fill(4'(b), 15);
         run_burst(4'(b), 32'(b * 64), 4'd15, 3'd2, 2'd1, 1'b0);
         wait_resp();
      end
      sweep("init");

      fill(4'h5, 3);
      for (int unsigned k = 0; k < 4; k++) bd[k] = 32'hA0 + k;
      run_burst(4'h5, 32'h10, 4'd3, 3'd2, 2'd1, 1'b0);
      wait_resp();
      for (int unsigned k = 0; k < 4; k++) begin
         read_word(4 + k, d);
         check($sformatf("incr_word%0d", 4 + k), d, 32'hA0 + k);
      end
      sweep("incr");

      fill(4'h6, 3);
      for (int unsigned k = 0; k < 4; k++) bd[k] = 32'hD0 + k;
      run_burst(4'h6, 32'h08, 4'd3, 3'd2, 2'd2, 1'b0);
      wait_resp();
      read_word(2, d); check("wrap_word2", d, 32'hD0);
      read_word(3, d); check("wrap_word3", d, 32'hD1);
      read_word(0, d); check("wrap_word0", d, 32'hD2);
      read_word(1, d); check("wrap_word1", d, 32'hD3);
      sweep("wrap");

      fill(4'h7, 0); bd[0] = 32'hFFFF_FFFF;
      run_burst(4'h7, 32'h0, 4'd0, 3'd2, 2'd1, 1'b0);
      wait_resp();
      fill(4'h7, 0); bd[0] = 32'h1122_3344; bs[0] = 4'h5;
      run_burst(4'h7, 32'h0, 4'd0, 3'd2, 2'd1, 1'b0);
      wait_resp();
      read_word(0, d); check("strobe_word0", d, 32'hFF22_FF44);

      fill(4'h8, 1); bl[0] = 1'b1;
      run_burst(4'h8, 32'h20, 4'd1, 3'd2, 2'd1, 1'b0);
      wait_resp();
      check("idle_after_early_last", AWREADY, 1);
      fill(4'h9, 1);
      run_burst(4'h9, 32'h30, 4'd1, 3'd3, 2'd1, 1'b0);
      wait_resp();
      fill(4'hA, 0);
      run_burst(4'hA, 32'(DEPTH * 4), 4'd0, 3'd2, 2'd1, 1'b0);
      wait_resp();
      sweep("errors");

      bp_mode = 2; bready_man = 1'b0;
      fill(4'hB, 1);
      run_burst(4'hB, 32'h100, 4'd1, 3'd2, 2'd1, 1'b0);
      n = 0;
      while (!BVALID && n < 50) begin @(negedge clk); n++; end
      check("bp_bvalid_seen", BVALID, 1);
      repeat (6) @(negedge clk);
      bready_man = 1'b1;
      wait_resp();
      bp_mode = 0;

      fill(4'hC, 3);
      r = model_burst(4'hC, 32'h80, 3, 2, 1, 2, nb);
      do_aw(4'hC, 32'h80, 4'd3, 3'd2, 2'd1);
      drive_beats(2, 1'b0);
      #3 rst_n = 1'b0;
      #1;
      check("abort_awready", AWREADY, 0);
      check("abort_wready", WREADY, 0);
      check("abort_bvalid", BVALID, 0);
      check("abort_bid", BID, 0);
      check("abort_bresp", BRESP, 0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      check("awready_after_abort", AWREADY, 1);
      sweep("abort");
      fill(4'hD, 2);
      run_burst(4'hD, 32'h90, 4'd2, 3'd2, 2'd1, 1'b0);
      wait_resp();

      fill(4'h3, 1); bw[1] = 4'h4;
      run_burst(4'h3, 32'h40, 4'd1, 3'd2, 2'd1, 1'b0);
      wait_resp();
      sweep("wid");

      bp_mode = 1;
      for (int unsigned t = 0; t < 40; t++) begin
         logic [3:0]  id, len;
         logic [2:0]  sz;
         logic [1:0]  bt;
         logic [31:0] addr;
         id   = 4'($urandom);
         len  = 4'($urandom);
         sz   = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
         bt   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         addr = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(1000, 1100)) : 32'($urandom_range(0, 1023));
         for (int unsigned k = 0; k < 16; k++) begin
            bd[k] = $urandom; bs[k] = 4'($urandom); bl[k] = (k == len); bw[k] = id;
         end
         if (len > 0 && $urandom_range(0, 5) == 0) bl[$urandom_range(0, len - 1)] = 1'b1;
         else if ($urandom_range(0, 7) == 0) bl[len] = 1'b0;
         run_burst(id, addr, len, sz, bt, 1'b1);
         wait_resp();
         sweep("rand");
      end
      bp_mode = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axi_wr_slave.md
Name: axi_wr_slave

Overview:
- AXI write-channel slave that sits directly downstream of the team's AXI bus-functional interface.
- Consumes the AW, W and B channels that the interface drives, and commits write data into an internal word-addressed memory with byte strobes.
- Returns a single write response per burst.
- Provides a combinational debug read port, so the bench can check memory contents without a read channel.

Parameters:
- WIDTH, 32, data/address width in bits; byte lanes = WIDTH/8.
- SIZE, 3, width of AWSIZE; AWBURST/BRESP are SIZE-1 bits.
- DEPTH, 256, memory depth in WIDTH-bit words; must be a power of 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- AWVALID  in  1  address valid.
- AWREADY  out  1  address ready.
- AWID  in  WIDTH/8  transaction ID.
- AWADDR  in  WIDTH  byte start address.
- AWLEN  in  WIDTH/8  beats minus 1.
- AWSIZE  in  SIZE  bytes per beat = 2^AWSIZE.
- AWBURST  in  SIZE-1  0 = FIXED, 1 = INCR, 2 = WRAP, 3 = reserved.
- WVALID  in  1  data valid.
- WREADY  out  1  data ready.
- WID  in  WIDTH/8  data ID.
- WDATA  in  WIDTH  write data.
- WSTRB  in  WIDTH/8  byte enables.
- WLAST  in  1  last beat.
- BVALID  out  1  response valid.
- BREADY  in  1  response ready.
- BID  out  WIDTH/8  response ID (latched AWID).
- BRESP  out  SIZE-1  0 = OKAY, 2 = SLVERR.
- dbg_addr  in  log2(DEPTH)  debug word index.
- dbg_rdata  out  WIDTH  mem[dbg_addr], combinational.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=0; beat counter=0; error flag=0. Memory contents are not reset.
- Reset asserted mid-burst: the burst is aborted and no response is issued. Beats already written stay in memory.
- FSM states: IDLE, DATA, RESP.
- IDLE:
  - AWREADY=1 from the first clock after reset release.
  - On AWVALID&AWREADY, latch id, addr, len, size, burst; clear counter and error flag; go to DATA.
  - AWREADY drops the cycle after the handshake.
- DATA:
  - WREADY=1.
  - Each WVALID&WREADY writes the WSTRB-selected byte lanes of mem[cur_addr / (WIDTH/8) mod 2^32] in the same cycle, visible on dbg_rdata the next cycle.
  - No lane steering: WSTRB is applied as given.
- Address advance after each beat:
  - FIXED: unchanged.
  - INCR: cur_addr += 2^size, 32-bit wrap.
  - WRAP: boundary = (len+1)*2^size. cur_addr = (cur_addr & ~(boundary-1)) | ((cur_addr + 2^size) & (boundary-1)).
- SLVERR conditions; each sets the sticky error flag:
  - burst == 3;
  - WRAP with len not in {1,3,7,15};
  - 2^size > WIDTH/8;
  - word index >= DEPTH.
- Beats under the first three conditions perform no writes. For out-of-range, only that beat is dropped.
- Beat counting and WLAST:
  - Counter increments per accepted beat.
  - Burst ends on the accepted beat where counter==len OR WLAST=1.
  - WLAST on a beat with counter!=len, or missing WLAST on counter==len, sets the error flag. The burst still ends on that beat.
- End of burst: go to RESP next cycle. WREADY=0 in RESP.
- RESP:
  - BVALID=1, BID=latched id, BRESP = error ? 2 : 0.
  - Hold stable until BREADY.
  - On BVALID&BREADY, go to IDLE; BVALID=0 the next cycle.
  - BREADY held high gives a 1-cycle response.
- Throughput: one beat per cycle in DATA. Minimum burst turnaround = len+4 cycles (AW, beats, RESP, IDLE).
- W beats presented in IDLE are not accepted (WREADY=0). No write-data interleaving; one outstanding burst at a time.

Optional Feature:
- Macro: AXI_WR_SLAVE_WID_CHECK_EN.
- Defined: each accepted beat compares WID with the latched AWID. A mismatch drops that beat's write and sets the error flag (SLVERR).
- Undefined: WID is ignored; there is no compare logic.

Test Plan:
- INCR, AWADDR=0x10, AWLEN=3, AWSIZE=2, WSTRB=0xF, data 0xA0..0xA3 with WLAST on beat 3, BREADY=1 -> mem[4..7]=0xA0..0xA3; BVALID for exactly 1 cycle; BRESP=0; BID=AWID.
- WRAP, AWADDR=0x08, AWLEN=3, AWSIZE=2, data D0..D3 -> words written in order 2,3,0,1; BRESP=0.
- Strobes: write 0xFFFFFFFF to word 0, then a single beat of 0x11223344 with WSTRB=0x5 -> mem[0]=0xFF22FF44.
- Error cases:
  - AWLEN=1 with WLAST on beat 0 -> BRESP=2, one write, return to IDLE.
  - AWSIZE=3 -> no writes, BRESP=2.
  - AWADDR=DEPTH*4 -> BRESP=2.
- Backpressure and reset:
  - BREADY held low 5 cycles -> BVALID, BID, BRESP stable for all 5 cycles; AWREADY=0 throughout.
  - reset pulsed low mid-burst after 2 beats -> all outputs 0 asynchronously, those 2 beats retained, the next AW is accepted normally.
- With AXI_WR_SLAVE_WID_CHECK_EN defined: AWID=3, WID=4 on beat 1 of 2 -> beat 1 not written, BRESP=2. Without the macro -> both beats written, BRESP=0.
